product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 98 +++++++++
 tb/tb_product_accumulator.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums batches of COUNT unsigned products from an upstream multiplier, then holds the
// result until the consumer acknowledges it. A product that arrives while a result is
// held is discarded and recorded in a sticky flag.
module product_accumulator #(
  parameter int unsigned BITS  = 4,
  parameter int unsigned COUNT = 4,
  parameter int unsigned GUARD = 2,
  localparam int unsigned PW   = 2 * BITS,
  localparam int unsigned SW   = 2 * BITS + GUARD,
  localparam int unsigned CW   = $clog2(COUNT + 1)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_valid,
  input  logic [PW-1:0] i_product,
  input  logic          i_ack,
  output logic [SW-1:0] o_sum,
  output logic [CW-1:0] o_count,
  output logic          o_done,
  output logic          o_overflow,
  output logic          o_dropped
);

  if (COUNT < 1) begin : g_bad_count
    $error("product_accumulator: COUNT must be at least 1");
  end

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e        state_q;
  logic [SW-1:0] sum_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          dropped_q;

  logic [SW-1:0] product_ext;
  logic [SW:0]   add_res;
  logic          last_product;

  // One extra bit captures the carry out of the modulo-2^SW sum.
  always_comb begin
    product_ext  = SW'(i_product);
    add_res      = {1'b0, sum_q} + {1'b0, product_ext};
    last_product = (count_q == CW'(COUNT - 1));
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= StAccum;
      sum_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (i_valid) begin
            sum_q      <= add_res[SW-1:0];
            overflow_q <= overflow_q | add_res[SW];
            count_q    <= count_q + CW'(1);
            if (last_product) begin
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          if (i_ack) begin
            overflow_q <= 1'b0;
            if (i_valid) begin
              // The ack frees the slot, so this product opens the next batch.
              sum_q   <= product_ext;
              count_q <= CW'(1);
              state_q <= (COUNT == 1) ? StHold : StAccum;
            end else begin
              sum_q   <= '0;
              count_q <= '0;
              state_q <= StAccum;
            end
          end else if (i_valid) begin
            dropped_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StAccum;
        end
      endcase
    end
  end

  always_comb begin
    o_sum      = sum_q;
    o_count    = count_q;
    o_done     = (state_q == StHold);
    o_overflow = overflow_q;
    o_dropped  = dropped_q;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench: a vector table drives the default-parameter instance; short
// hand-written sequences cover the GUARD=1 wrap and the COUNT=1 variant.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] product;
  logic       ack;

  logic [9:0] sum_d;
  logic [2:0] cnt_d;
  logic       done_d, ovf_d, drop_d;

  logic [8:0] sum_g;
  logic [2:0] cnt_g;
  logic       done_g, ovf_g, drop_g;

  logic [9:0] sum_c;
  logic [0:0] cnt_c;
  logic       done_c, ovf_c, drop_c;

  always #5 clk = ~clk;

  product_accumulator dut (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_product(product), .i_ack(ack),
    .o_sum(sum_d), .o_count(cnt_d), .o_done(done_d), .o_overflow(ovf_d),
    .o_dropped(drop_d)
  );

  product_accumulator #(.BITS(4), .COUNT(4), .GUARD(1)) dut_g1 (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_product(product), .i_ack(ack),
    .o_sum(sum_g), .o_count(cnt_g), .o_done(done_g), .o_overflow(ovf_g),
    .o_dropped(drop_g)
  );

  product_accumulator #(.BITS(4), .COUNT(1), .GUARD(2)) dut_c1 (
    .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_product(product), .i_ack(ack),
    .o_sum(sum_c), .o_count(cnt_c), .o_done(done_c), .o_overflow(ovf_c),
    .o_dropped(drop_c)
  );

  typedef struct {
    logic v; logic [7:0] p; logic px; logic a; logic r;
    int sum; int cnt; logic done; logic ovf; logic drop;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(logic v, int p, logic px, logic a, logic r,
                              int sum, int cnt, logic done, logic ovf, logic drop);
    vec_t e;
    e.v = v; e.p = 8'(p); e.px = px; e.a = a; e.r = r;
    e.sum = sum; e.cnt = cnt; e.done = done; e.ovf = ovf; e.drop = drop;
    tbl.push_back(e);
  endfunction

  task automatic chk(string name, int idx, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step(logic v, logic [7:0] p, logic px, logic a, logic r);
    valid   = v;
    product = px ? 8'bx : p;
    ack     = a;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_g(string name, int sum, int cnt, logic done, logic ovf);
    chk({name, "_sum"}, 0, int'(sum_g), sum);
    chk({name, "_cnt"}, 0, int'(cnt_g), cnt);
    chk({name, "_done"}, 0, int'(done_g), int'(done));
    chk({name, "_ovf"}, 0, int'(ovf_g), int'(ovf));
  endtask

  task automatic chk_c(string name, int sum, int cnt, logic done);
    chk({name, "_sum"}, 0, int'(sum_c), sum);
    chk({name, "_cnt"}, 0, int'(cnt_c), cnt);
    chk({name, "_done"}, 0, int'(done_c), int'(done));
  endtask

  initial begin
    valid = 1'b0; product = '0; ack = 1'b0; rst = 1'b1;

    // Four 143 products spaced five cycles apart.
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      add(1, 143, 0, 0, 0, 143 * k, k, (k == 4), 0, 0);
      if (k < 4) for (int j = 0; j < 4; j++) add(0, 0, 0, 0, 0, 143 * k, k, 0, 0, 0);
    end
    add(0, 0, 0, 0, 0, 572, 4, 1, 0, 0);
    // Product arriving during HOLD is dropped.
    add(1, 25, 0, 0, 0, 572, 4, 1, 0, 1);
    add(0, 0, 0, 0, 0, 572, 4, 1, 0, 1);
    // Ack with a simultaneous product opens the next batch with it.
    add(1, 50, 0, 1, 0, 50, 1, 0, 0, 1);
    add(1, 100, 0, 0, 0, 150, 2, 0, 0, 1);
    add(1, 200, 0, 0, 0, 350, 3, 0, 0, 1);
    add(1, 255, 0, 0, 0, 605, 4, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    // Mid-batch reset wins over a valid product.
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 143, 0, 0, 0, 143, 1, 0, 0, 0);
    add(1, 143, 0, 0, 0, 286, 2, 0, 0, 0);
    add(1, 143, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(1, 1, 0, 0, 0, k, k, (k == 4), 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Unknown product with valid low, then a stray ack in ACCUM.
    add(1, 7, 0, 0, 0, 7, 1, 0, 0, 0);
    for (int j = 0; j < 10; j++) add(0, 0, 1, 0, 0, 7, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 7, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].p, tbl[i].px, tbl[i].a, tbl[i].r);
      chk("sum", i, int'(sum_d), tbl[i].sum);
      chk("count", i, int'(cnt_d), tbl[i].cnt);
      chk("done", i, int'(done_d), int'(tbl[i].done));
      chk("overflow", i, int'(ovf_d), int'(tbl[i].ovf));
      chk("dropped", i, int'(drop_d), int'(tbl[i].drop));
    end

    // GUARD=1: 572 wraps to 60 in a 9-bit sum.
    step(0, 0, 0, 0, 1);
    chk_g("g1_reset", 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) step(1, 143, 0, 0, 0);
    chk_g("g1_three", 429, 3, 0, 0);
    step(1, 143, 0, 0, 0);
    chk_g("g1_wrap", 60, 4, 1, 1);
    step(0, 0, 0, 1, 0);
    chk_g("g1_ack", 0, 0, 0, 0);
    // Overflow stays set for the rest of the batch.
    step(1, 255, 0, 0, 0);
    step(1, 255, 0, 0, 0);
    chk_g("g1_510", 510, 2, 0, 0);
    step(1, 255, 0, 0, 0);
    chk_g("g1_carry", 253, 3, 0, 1);
    step(1, 1, 0, 0, 0);
    chk_g("g1_sticky", 254, 4, 1, 1);

    // COUNT=1: every accepted product lands directly in HOLD.
    step(0, 0, 0, 0, 1);
    chk_c("c1_reset", 0, 0, 0);
    step(1, 9, 0, 0, 0);
    chk_c("c1_first", 9, 1, 1);
    step(1, 5, 0, 1, 0);
    chk_c("c1_ackval", 5, 1, 1);
    chk("c1_nodrop", 0, int'(drop_c), 0);
    step(0, 0, 0, 1, 0);
    chk_c("c1_ack", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
